// File: rtl/addsub_pipe.sv
// Pipelined add/sub with a segmented carry chain and a valid/ready handshake.
// Build option ADDSUB_SAT_EN adds a per-beat sat input that clamps on overflow.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             use_cin,
  input  logic             cin,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SEG = WIDTH / STAGES;
  localparam int L   = STAGES - 1;

  logic              en;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c;
  logic [STAGES-1:0] iv;
  logic [STAGES-1:0] ic;
  logic [STAGES-1:0] nc;
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [WIDTH-1:0]  rr [STAGES];
  logic [WIDTH-1:0]  ia [STAGES];
  logic [WIDTH-1:0]  ib [STAGES];
  logic [WIDTH-1:0]  ir [STAGES];
  logic [WIDTH-1:0]  nr [STAGES];
  logic [SEG:0]      t;
  logic              cm;
  logic              ov;
  logic [WIDTH-1:0]  fin;
`ifdef ADDSUB_SAT_EN
  logic [STAGES-1:0] rs;
  logic [STAGES-1:0] si;
`endif

  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = v[L];
  assign result    = rr[L];
  assign carry     = c[L];

  // Stage k owns bits [k*SEG +: SEG]; operands ride along untouched.
  always_comb begin
    iv[0] = in_valid;
    ia[0] = a;
    ib[0] = op_sub ? ~b : b;
    ir[0] = '0;
    ic[0] = use_cin ? cin : op_sub;
    for (int k = 1; k < STAGES; k++) begin
      iv[k] = v[k-1];
      ia[k] = ra[k-1];
      ib[k] = rb[k-1];
      ir[k] = rr[k-1];
      ic[k] = c[k-1];
    end
    t = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, ia[k][k*SEG +: SEG]}
        + {1'b0, ib[k][k*SEG +: SEG]}
        + {{SEG{1'b0}}, ic[k]};
      nr[k] = ir[k];
      nr[k][k*SEG +: SEG] = t[SEG-1:0];
      nc[k] = t[SEG];
    end
  end

`ifdef ADDSUB_SAT_EN
  always_comb begin
    si[0] = sat;
    for (int k = 1; k < STAGES; k++) si[k] = rs[k-1];
  end
`endif

  // Carry into the MSB recovered from the MSB sum bit.
  always_comb begin
    cm  = nr[L][WIDTH-1] ^ ia[L][WIDTH-1] ^ ib[L][WIDTH-1];
    ov  = cm ^ nc[L];
    fin = nr[L];
`ifdef ADDSUB_SAT_EN
    if (si[L] && ov)
      fin = nr[L][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                           : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v        <= '0;
      c        <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rr[k] <= '0;
      end
`ifdef ADDSUB_SAT_EN
      rs <= '0;
`endif
    end else if (en) begin
      v <= iv;
      c <= nc;
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= ia[k];
        rb[k] <= ib[k];
        rr[k] <= nr[k];
      end
      rr[L]    <= fin;
      overflow <= ov;
      zero     <= (fin == '0);
      negative <= fin[WIDTH-1];
`ifdef ADDSUB_SAT_EN
      rs <= si;
`endif
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe at depths 4, 1 and 16 (WIDTH=16).
// Reference model works on signed/unsigned integer arithmetic.
module tb_addsub_pipe;

  typedef struct packed {
    logic [15:0] r;
    logic c;
    logic v;
    logic z;
    logic n;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic sub;
    logic uc;
    logic ci;
    logic st;
    logic [15:0] r;
    logic c;
    logic v;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, op_sub, use_cin, cin, sat, out_ready;
  logic [15:0] a, b;
  logic rdy [3];
  logic ovl [3];
  logic cy [3];
  logic vf [3];
  logic zf [3];
  logic nf [3];
  logic [15:0] res [3];

  int checks = 0;
  int errors = 0;
  int lat_exp [3] = '{4, 1, 16};

  int got_lat [3];
  int cnt [3];
  exp_t cap [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    addsub_pipe #(.WIDTH(16), .STAGES(S)) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(rdy[g]),
      .a(a),
      .b(b),
      .op_sub(op_sub),
      .use_cin(use_cin),
      .cin(cin),
`ifdef ADDSUB_SAT_EN
      .sat(sat),
`endif
      .out_valid(ovl[g]),
      .out_ready(out_ready),
      .result(res[g]),
      .carry(cy[g]),
      .overflow(vf[g]),
      .zero(zf[g]),
      .negative(nf[g])
    );
  end

  function automatic exp_t model(logic [15:0] x, logic [15:0] y,
                                 logic sub, logic uc, logic ci,
                                 logic st);
    exp_t e;
    int ce, u, s;
    logic [15:0] yy;
    ce = uc ? int'(ci) : int'(sub);
    yy = sub ? ~y : y;
    u = int'(x) + int'(yy) + ce;
    s = int'($signed(x)) + int'($signed(yy)) + ce;
    e.r = u[15:0];
    e.c = (u > 65535);
    e.v = (s > 32767) || (s < -32768);
`ifdef ADDSUB_SAT_EN
    if (st && e.v) e.r = (s > 0) ? 16'h7FFF : 16'h8000;
`else
    if (st && 1'b0) e.r = 16'h0;
`endif
    e.z = (e.r == 16'h0);
    e.n = e.r[15];
    return e;
  endfunction

  function automatic exp_t outs(int d);
    return {res[d], cy[d], vf[d], zf[d], nf[d]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    a = '0; b = '0;
    op_sub = 0; use_cin = 0; cin = 0; sat = 0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_one(logic [15:0] x, logic [15:0] y, logic sub,
                          logic uc, logic ci, logic st);
    a = x; b = y; op_sub = sub; use_cin = uc; cin = ci; sat = st;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      got_lat[d] = -1;
      cnt[d] = 0;
      cap[d] = '0;
    end
    @(posedge clk); #1;
    idle();
    for (int n = 1; n <= 40; n++) begin
      for (int d = 0; d < 3; d++) begin
        if (ovl[d] === 1'b1) begin
          cnt[d]++;
          if (got_lat[d] < 0) begin
            got_lat[d] = n;
            cap[d] = outs(d);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ovl[d], outs(d), rdy[d]} !== 22'h1) begin
        errors++;
        $display("FAIL reset_state d%0d got %h want 000001",
                 d, {ovl[d], outs(d), rdy[d]});
      end
    end
  endtask

  task automatic test_arith();
    vec_t tv [9];
    exp_t e;
    tv[0] = '{16'h0005, 16'h0003, 1, 0, 0, 0, 16'h0002, 1, 0};
    tv[1] = '{16'h0003, 16'h0005, 1, 0, 0, 0, 16'hFFFE, 0, 0};
    tv[2] = '{16'h8000, 16'h0001, 1, 0, 0, 0, 16'h7FFF, 1, 1};
    tv[4] = '{16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 0};
    tv[5] = '{16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 0, 1};
`ifdef ADDSUB_SAT_EN
    tv[3] = '{16'h8000, 16'h0001, 1, 0, 0, 1, 16'h8000, 1, 1};
    tv[6] = '{16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h7FFF, 0, 1};
`else
    tv[3] = '{16'h8000, 16'h0001, 1, 0, 0, 1, 16'h7FFF, 1, 1};
    tv[6] = '{16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 0, 1};
`endif
    tv[7] = '{16'h1234, 16'h0001, 0, 1, 1, 0, 16'h1236, 0, 0};
    tv[8] = '{16'h0005, 16'h0003, 1, 1, 0, 0, 16'h0001, 1, 0};
    for (int i = 0; i < 9; i++) begin
      send_one(tv[i].x, tv[i].y, tv[i].sub, tv[i].uc, tv[i].ci, tv[i].st);
      e = '{tv[i].r, tv[i].c, tv[i].v, tv[i].r == 16'h0, tv[i].r[15]};
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (got_lat[d] !== lat_exp[d] || cnt[d] !== 1) begin
          errors++;
          $display("FAIL arith_latency v%0d d%0d got lat %0d cnt %0d want lat %0d cnt 1",
                   i, d, got_lat[d], cnt[d], lat_exp[d]);
        end
        checks++;
        if (cap[d] !== e) begin
          errors++;
          $display("FAIL arith_value v%0d d%0d got %h want %h",
                   i, d, cap[d], e);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t mem [3][256];
    int wr [3];
    int rd [3];
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      wr[d] = 0;
      rd[d] = 0;
    end
    do_reset();
    for (int cyc = 0; cyc < 640; cyc++) begin
      if (cyc < 600) begin
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a = pick(); b = pick();
        op_sub = 1'($urandom); use_cin = 1'($urandom);
        cin = 1'($urandom); sat = 1'($urandom);
      end else begin
        idle();
        out_ready = 1'b1;
      end
      #1;
      e = model(a, b, op_sub, use_cin, cin, sat);
      for (int d = 0; d < 3; d++) begin
        if (ovl[d] === 1'b1 && out_ready) begin
          checks++;
          if (rd[d] == wr[d]) begin
            errors++;
            $display("FAIL rand_extra d%0d cyc %0d got %h want none",
                     d, cyc, outs(d));
          end else begin
            if (outs(d) !== mem[d][rd[d] % 256]) begin
              errors++;
              $display("FAIL rand_value d%0d beat %0d got %h want %h",
                       d, rd[d], outs(d), mem[d][rd[d] % 256]);
            end
            rd[d]++;
          end
        end
        if (in_valid && rdy[d] === 1'b1) begin
          mem[d][wr[d] % 256] = e;
          wr[d]++;
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rd[d] != wr[d]) begin
        errors++;
        $display("FAIL rand_count d%0d got %0d want %0d", d, rd[d], wr[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [15:0] bx [8];
    logic [15:0] by [8];
    logic bs [8];
    exp_t be [8];
    exp_t prev;
    logic held;
    int sent, got, cyc;
    for (int i = 0; i < 8; i++) begin
      bx[i] = pick();
      by[i] = pick();
      bs[i] = 1'($urandom);
      be[i] = model(bx[i], by[i], bs[i], 1'b0, 1'b0, 1'b0);
    end
    do_reset();
    sent = 0; got = 0; held = 0; prev = '0; cyc = 0;
    while (cyc < 200 && got < 8) begin
      out_ready = pat[cyc % 7];
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = bx[sent]; b = by[sent]; op_sub = bs[sent];
      end
      #1;
      checks++;
      if (rdy[0] !== !(ovl[0] && !out_ready)) begin
        errors++;
        $display("FAIL stall_ready cyc %0d got %b want %b",
                 cyc, rdy[0], !(ovl[0] && !out_ready));
      end
      if (held) begin
        checks++;
        if ({ovl[0], outs(0)} !== {1'b1, prev}) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got %h want %h",
                   cyc, {ovl[0], outs(0)}, {1'b1, prev});
        end
      end
      if (ovl[0] === 1'b1 && out_ready) begin
        checks++;
        if (outs(0) !== be[got]) begin
          errors++;
          $display("FAIL stall_order beat %0d got %h want %h",
                   got, outs(0), be[got]);
        end
        got++;
      end
      if (in_valid && rdy[0] === 1'b1) sent++;
      held = (ovl[0] === 1'b1) && !out_ready;
      prev = outs(0);
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL stall_count got %0d want 8", got);
    end
    idle();
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (ovl[0] === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stall_dup cyc %0d got %h want none", n, outs(0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_flush();
    int stale;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 + 16'(i); b = 16'h0010; op_sub = 0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ovl[d], outs(d), rdy[d]} !== 22'h1) begin
        errors++;
        $display("FAIL flush_state d%0d got %h want 000001",
                 d, {ovl[d], outs(d), rdy[d]});
      end
    end
    stale = 0;
    for (int n = 0; n < 20; n++) begin
      for (int d = 0; d < 3; d++)
        if (ovl[d] === 1'b1) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL flush_stale got %0d want 0", stale);
    end
    send_one(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (got_lat[d] !== lat_exp[d] || cap[d] !== {16'h3333, 4'b0000}) begin
        errors++;
        $display("FAIL flush_next d%0d got lat %0d %h want lat %0d 33330",
                 d, got_lat[d], cap[d], lat_exp[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_random();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
